// File: rtl/mips_pkg.sv
// Shared constants for the MIPS control/ALU slice: opcodes, funct codes,
// ALU-control codes and bit positions inside the control bundles.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_INV = 4'b1111
  } alu_ctrl_e;

  // ex = {RegDst, ALUOp[1:0], ALUSrc}; mem = {Branch, MemRead, MemWrite};
  // wb = {RegWrite, MemtoReg}
  localparam int unsigned EX_REGDST   = 3;
  localparam int unsigned EX_ALUOP_HI = 2;
  localparam int unsigned EX_ALUOP_LO = 1;
  localparam int unsigned EX_ALUSRC   = 0;
  localparam int unsigned MEM_BRANCH  = 2;
  localparam int unsigned MEM_READ    = 1;
  localparam int unsigned MEM_WRITE   = 0;
  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU with zero flag; unknown control codes yield 0.
module mips_alu
  import mips_pkg::*;
(
  input  logic [3:0]  ctrl_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  always_comb begin
    result_o = '0;
    case (ctrl_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_NOR: result_o = ~(a_i | b_i);
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_SLT: result_o[0] = ($signed(a_i) < $signed(b_i));
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/mips_ctrl_alu_stage.sv
// Main decode in ID, ID/EX register, then ALU-control decode and ALU in EX.
module mips_ctrl_alu_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] imm,
  output logic        jump,
  output logic [3:0]  ex_ctrl,
  output logic [2:0]  mem_ctrl,
  output logic [1:0]  wb_ctrl,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_result,
  output logic        zero
);

  logic [3:0]  ex_d, ex_q;
  logic [2:0]  mem_d, mem_q;
  logic [1:0]  wb_d, wb_q;
  logic [31:0] rs_q, rt_q, imm_q;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] data2;
  alu_ctrl_e   ctrl;

  always_comb begin
    jump  = 1'b0;
    ex_d  = '0;
    mem_d = '0;
    wb_d  = '0;
    case (opcode)
      OP_RTYPE: begin ex_d = 4'b0101; wb_d = 2'b11; end
      OP_LW:    begin ex_d = 4'b1000; mem_d = 3'b010; wb_d = 2'b10; end
      OP_SW:    begin ex_d = 4'b1000; mem_d = 3'b001; end
      OP_BEQ:   begin ex_d = 4'b0011; mem_d = 3'b100; end
      OP_ADDI:  begin ex_d = 4'b1000; wb_d = 2'b11; end
      OP_J:     jump = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      imm_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      rs_q  <= rs_data;
      rt_q  <= rt_data;
      imm_q <= imm;
    end
  end

  assign alu_op = ex_q[EX_ALUOP_HI:EX_ALUOP_LO];
  assign funct  = imm_q[5:0];

  always_comb begin
    ctrl = ALU_ADD;
    case (alu_op)
      2'b01: ctrl = ALU_SUB;
      2'b10: begin
        case (funct)
          FN_ADD:  ctrl = ALU_ADD;
          FN_SUB:  ctrl = ALU_SUB;
          FN_AND:  ctrl = ALU_AND;
          FN_OR:   ctrl = ALU_OR;
          FN_SLT:  ctrl = ALU_SLT;
          FN_NOR:  ctrl = ALU_NOR;
          default: ctrl = ALU_INV;
        endcase
      end
      default: ctrl = ALU_ADD;
    endcase
  end

  // ALUSrc=1 picks the register operand, 0 picks the immediate.
  assign data2 = ex_q[EX_ALUSRC] ? rt_q : imm_q;

  mips_alu u_alu (
    .ctrl_i   (ctrl),
    .a_i      (rs_q),
    .b_i      (data2),
    .result_o (alu_result),
    .zero_o   (zero)
  );

  assign ex_ctrl  = ex_q;
  assign mem_ctrl = mem_q;
  assign wb_ctrl  = wb_q;
  assign alu_ctrl = ctrl;

endmodule

// File: tb/tb_mips_ctrl_alu_stage.sv
// Directed-vector bench for mips_ctrl_alu_stage: table of instructions plus
// hand-written asynchronous-reset sequences.
module tb_mips_ctrl_alu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic [31:0] rs_data, rt_data, imm;
  logic        jump;
  logic [3:0]  ex_ctrl;
  logic [2:0]  mem_ctrl;
  logic [1:0]  wb_ctrl;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  mips_ctrl_alu_stage dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .imm        (imm),
    .jump       (jump),
    .ex_ctrl    (ex_ctrl),
    .mem_ctrl   (mem_ctrl),
    .wb_ctrl    (wb_ctrl),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .zero       (zero)
  );

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] rs, rt, im;
    logic        jmp;
    logic [3:0]  ex;
    logic [2:0]  mem;
    logic [1:0]  wb;
    logic [3:0]  ctl;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(string n, logic [5:0] op, logic [31:0] rs,
                              logic [31:0] rt, logic [31:0] im, logic jmp,
                              logic [3:0] ex, logic [2:0] mem, logic [1:0] wb,
                              logic [3:0] ctl, logic [31:0] res, logic z);
    vec_t v;
    v.name = n; v.op = op; v.rs = rs; v.rt = rt; v.im = im; v.jmp = jmp;
    v.ex = ex; v.mem = mem; v.wb = wb; v.ctl = ctl; v.res = res; v.z = z;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_regs(string n, logic [3:0] ex, logic [2:0] mem,
                          logic [1:0] wb, logic [3:0] ctl, logic [31:0] res,
                          logic z);
    chk({n, ".ex"},   {28'd0, ex_ctrl},  {28'd0, ex});
    chk({n, ".mem"},  {29'd0, mem_ctrl}, {29'd0, mem});
    chk({n, ".wb"},   {30'd0, wb_ctrl},  {30'd0, wb});
    chk({n, ".ctl"},  {28'd0, alu_ctrl}, {28'd0, ctl});
    chk({n, ".res"},  alu_result,        res);
    chk({n, ".zero"}, {31'd0, zero},     {31'd0, z});
  endtask

  task automatic drive(logic [5:0] op, logic [31:0] rs, logic [31:0] rt,
                       logic [31:0] im);
    opcode = op; rs_data = rs; rt_data = rt; imm = im;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tv.push_back(mk("r_add",   6'h00, 32'd7,        32'd5,        32'h20,       0, 4'b0101, 3'b000, 2'b11, 4'b0010, 32'd12,       0));
    tv.push_back(mk("r_slt0",  6'h00, 32'd7,        32'd5,        32'h2A,       0, 4'b0101, 3'b000, 2'b11, 4'b0111, 32'd0,        1));
    tv.push_back(mk("r_slt_n", 6'h00, 32'hFFFFFFFF, 32'd1,        32'h2A,       0, 4'b0101, 3'b000, 2'b11, 4'b0111, 32'd1,        0));
    tv.push_back(mk("r_slt_s", 6'h00, 32'd1,        32'hFFFFFFFF, 32'h2A,       0, 4'b0101, 3'b000, 2'b11, 4'b0111, 32'd0,        1));
    tv.push_back(mk("r_slt_m", 6'h00, 32'h80000000, 32'h7FFFFFFF, 32'h2A,       0, 4'b0101, 3'b000, 2'b11, 4'b0111, 32'd1,        0));
    tv.push_back(mk("lw",      6'h23, 32'h100,      32'h1234,     32'hFFFFFFFC, 0, 4'b1000, 3'b010, 2'b10, 4'b0010, 32'hFC,       0));
    tv.push_back(mk("sw",      6'h2B, 32'h200,      32'hDEAD,     32'h8,        0, 4'b1000, 3'b001, 2'b00, 4'b0010, 32'h208,      0));
    tv.push_back(mk("beq_eq",  6'h04, 32'h55,       32'h55,       32'h10,       0, 4'b0011, 3'b100, 2'b00, 4'b0110, 32'd0,        1));
    tv.push_back(mk("beq_ne",  6'h04, 32'h55,       32'h56,       32'h10,       0, 4'b0011, 3'b100, 2'b00, 4'b0110, 32'hFFFFFFFF, 0));
    tv.push_back(mk("addi",    6'h08, 32'd10,       32'd77,       32'hFFFFFFFF, 0, 4'b1000, 3'b000, 2'b11, 4'b0010, 32'd9,        0));
    tv.push_back(mk("j",       6'h02, 32'd3,        32'd4,        32'd0,        1, 4'b0000, 3'b000, 2'b00, 4'b0010, 32'd3,        0));
    tv.push_back(mk("undef_op",6'h3F, 32'd0,        32'd9,        32'd0,        0, 4'b0000, 3'b000, 2'b00, 4'b0010, 32'd0,        1));
    tv.push_back(mk("add_wrap",6'h00, 32'hFFFFFFFF, 32'd1,        32'h20,       0, 4'b0101, 3'b000, 2'b11, 4'b0010, 32'd0,        1));
    tv.push_back(mk("nor00",   6'h00, 32'd0,        32'd0,        32'h27,       0, 4'b0101, 3'b000, 2'b11, 4'b1100, 32'hFFFFFFFF, 0));
    tv.push_back(mk("bad_fn",  6'h00, 32'd7,        32'd5,        32'h00,       0, 4'b0101, 3'b000, 2'b11, 4'b1111, 32'd0,        1));
    tv.push_back(mk("sub",     6'h00, 32'd5,        32'd7,        32'h22,       0, 4'b0101, 3'b000, 2'b11, 4'b0110, 32'hFFFFFFFE, 0));
    tv.push_back(mk("and",     6'h00, 32'hF0F0,     32'hFF00,     32'h24,       0, 4'b0101, 3'b000, 2'b11, 4'b0000, 32'hF000,     0));
    tv.push_back(mk("or",      6'h00, 32'hF0F0,     32'h0F00,     32'h25,       0, 4'b0101, 3'b000, 2'b11, 4'b0001, 32'hFFF0,     0));

    // Reset state at power-up
    rst = 1'b1;
    drive(6'h00, 32'd0, 32'd0, 32'd0);
    #1;
    chk_regs("por", 4'd0, 3'd0, 2'd0, 4'b0010, 32'd0, 1'b1);
    chk("por.jump", {31'd0, jump}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].op, tv[i].rs, tv[i].rt, tv[i].im);
      #1;
      chk({tv[i].name, ".jump"}, {31'd0, jump}, {31'd0, tv[i].jmp});
      @(posedge clk);
      #1;
      chk_regs(tv[i].name, tv[i].ex, tv[i].mem, tv[i].wb, tv[i].ctl,
               tv[i].res, tv[i].z);
    end

    // Mid-run asynchronous reset: capture lw, then assert rst between edges
    @(negedge clk);
    drive(6'h23, 32'h100, 32'h0, 32'hFFFFFFFC);
    @(posedge clk);
    #1;
    chk_regs("pre_rst", 4'b1000, 3'b010, 2'b10, 4'b0010, 32'hFC, 1'b0);
    #2;
    rst = 1'b1;
    opcode = 6'h02;
    #1;
    chk_regs("async_rst", 4'd0, 3'd0, 2'd0, 4'b0010, 32'd0, 1'b1);
    chk("async_rst.jump", {31'd0, jump}, 32'd1);
    @(posedge clk);
    #1;
    chk_regs("held_rst", 4'd0, 3'd0, 2'd0, 4'b0010, 32'd0, 1'b1);

    // Release: nothing is captured until the following posedge
    @(negedge clk);
    rst = 1'b0;
    drive(6'h00, 32'd7, 32'd5, 32'h20);
    #1;
    chk_regs("post_rel", 4'd0, 3'd0, 2'd0, 4'b0010, 32'd0, 1'b1);
    chk("post_rel.jump", {31'd0, jump}, 32'd0);
    @(posedge clk);
    #1;
    chk_regs("first_cap", 4'b0101, 3'b000, 2'b11, 4'b0010, 32'd12, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
